cordic_freq_sched: RTL
======================

// Module: cordic_freq_sched
// PURPOSE
//  Time-shares one sequential `divider` among NCH sine/cosine generator channels.
//  Each channel requests a new output frequency. The block computes the phase
//  increment (quotient, remainder) = freq / discr_freq, stages the result per
//  channel, and commits every staged increment together on the sample strobe.
//  Sits between the control/register side and the per-channel phase accumulators
//  that drive `cordic_phase`.
// PARAMETERS
//  NCH    4   number of requesting channels (1..16)
//  FW     16  frequency word width
//  AW     20  phase-increment width; max phase TWO_PI = 2^(AW-1)-1
//  DW     32  divider operand width, matching `divider #32`
// PORTS
//  clk            in   1       system clock
//  rst_n          in   1       reset, asynchronous, active-low
//  req            in   NCH     level request per channel: new frequency pending
//  freq_in        in   NCH*FW  per-channel requested frequency; ch i = [i*FW +: FW]
//  discr_freq     in   FW      common divisor (sample rate), static while busy
//  sample_en      in   1       one-cycle sample strobe; commit point
//  div_start      out  1       one-cycle start pulse to the shared divider
//  div_dividend   out  DW      {0, captured freq}
//  div_divisor    out  DW      {0, captured discr_freq}
//  div_quotient   in   DW      divider quotient, valid on div_ready
//  div_remainder  in   DW      divider remainder, valid on div_ready
//  div_ready      in   1       one-cycle divider done pulse
//  ack            out  NCH     one-cycle pulse: channel result staged (or rejected)
//  inc_arg        out  NCH*AW  active integer phase increment per channel
//  inc_rem        out  NCH*AW  active fractional remainder per channel
//  busy           out  1       FSM not in IDLE
//  err_div0       out  1       sticky: a request was rejected because discr_freq==0
//  err_sat        out  1       sticky: a quotient was clamped
// BEHAVIOUR
//  - Reset values: all outputs 0; staged registers 0; pending flags 0;
//    round-robin pointer at ch0.
//  - FSM states: IDLE -> START -> WAIT -> STORE -> IDLE.
//  - IDLE: if any req is high, grant the first requesting channel at or after
//    rr_ptr (wrapping). Capture freq_in[g] and discr_freq into operand registers,
//    then go to START.
//  - IDLE, divide-by-zero: if the captured discr_freq == 0, go straight to STORE
//    with reject set. No div_start is issued, err_div0 is set, and the staged value
//    is not changed.
//  - START: div_start=1 for exactly one cycle, then go to WAIT. Operands stay
//    stable from START until leaving WAIT.
//  - WAIT: hold until div_ready, then latch the quotient and remainder and go to STORE.
//    div_ready seen in any other state is ignored. This covers a stale pulse after
//    reset mid-divide.
//  - STORE: ack[g]=1 for one cycle. Unless rejected, write the staged (arg, rem) for g
//    and set pending[g]. Then rr_ptr = g+1 mod NCH.
//  - Saturation: if div_quotient[DW-1:AW-1] != 0, stage arg = 2^(AW-1)-1, rem = 0,
//    and set err_sat. Otherwise arg = quotient[AW-1:0] and rem = remainder[AW-1:0].
//  - Latency, grant to ack: 3 cycles + divider latency. A rejected request takes
//    2 cycles.
//  - Commit: on sample_en, every channel with pending=1 copies staged to inc_arg and
//    inc_rem and clears pending.
//  - STORE and sample_en in the same cycle: commit uses the staged value from before
//    that edge. The new result stays pending and commits at the next sample_en.
//  - req dropped before grant: the request is lost, with no ack. req held after ack:
//    the channel re-arbitrates, and round-robin prevents starvation.
//  - A freq_in change after capture does not affect the divide in flight.
//  - err flags clear only on reset.
// STRUCTURE
//  - Shared package cordic_pkg:
//    - FSM state enum
//    - TWO_PI / AW / DW constants, also used by cordic_gen
//  - One natural sub-module, rr_arbiter (NCH-wide, pointer-based, one-hot grant).
//  - The divider stays external so it can be shared.
// TESTING (NCH=4, discr_freq=8000, behavioural divider with 34-cycle latency)
//  1. ch1 freq=20000 -> div_start once with dividend=20000 and divisor=8000.
//     ack[1] comes 37 cycles after grant. After the next sample_en, inc_arg1=2 and
//     inc_rem1=4000.
//  2. req=4'b1111 held -> grants in order 0,1,2,3,0. Exactly one div_start per ack.
//  3. discr_freq=0, ch2 req -> no div_start, ack[2] 2 cycles after grant,
//     err_div0=1, inc_arg2 unchanged.
//  4. Divider returns quotient=0x100000 -> inc_arg = 524287, inc_rem = 0, err_sat=1.
//  5. STORE coincides with sample_en -> active value still old; new value appears
//     after the following sample_en.
//  6. rst_n low during WAIT, then a stray div_ready -> all outputs 0, FSM IDLE,
//     no ack, stray ready ignored.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC frequency path: scheduler FSM states and
// phase-word constants, also consumed by cordic_gen.
// Latency: n/a (declarations only). Backpressure: n/a.
package cordic_pkg;

  // Phase-increment width and the divider operand width it is paired with.
  localparam int AW     = 20;
  localparam int DW     = 32;
  // Largest representable phase; also the clamp value for oversized increments.
  localparam int TWO_PI = (1 << (AW - 1)) - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_STORE = 2'd3
  } state_t;

endpackage

// File: rtl/cordic_freq_sched_if.sv
// Port bundle between the scheduler and the shared sequential divider.
// Latency: set by the divider; div_ready is a one-cycle done pulse.
// Backpressure: none; operands are held stable by the master until div_ready.
//   div_start     master->slave  one-cycle start pulse
//   div_dividend  master->slave  dividend operand
//   div_divisor   master->slave  divisor operand
//   div_quotient  slave->master  quotient, valid with div_ready
//   div_remainder slave->master  remainder, valid with div_ready
//   div_ready     slave->master  one-cycle done pulse
interface cordic_freq_sched_if #(
  parameter int DW = 32
) ();
  logic          div_start;
  logic [DW-1:0] div_dividend;
  logic [DW-1:0] div_divisor;
  logic [DW-1:0] div_quotient;
  logic [DW-1:0] div_remainder;
  logic          div_ready;

  modport master (
    output div_start, div_dividend, div_divisor,
    input  div_quotient, div_remainder, div_ready
  );

  modport slave (
    input  div_start, div_dividend, div_divisor,
    output div_quotient, div_remainder, div_ready
  );
endinterface

// File: rtl/cordic_freq_sched_rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr (wrapping) wins.
// Latency: combinational. Backpressure: none; caller decides when to take gnt.
//   req in NCH; ptr in PW; gnt out NCH one-hot; gnt_idx out PW; any out 1
module rr_arbiter #(
  parameter int NCH = 4,
  parameter int PW  = 2
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [PW-1:0]  gnt_idx,
  output logic           any
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      automatic int idx = (int'(ptr) + k) % NCH;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/cordic_freq_sched.sv
// Time-shares one external divider among NCH channels to turn requested
// frequencies into phase increments, staged per channel and committed together
// on sample_en. Latency grant->ack: 3 cycles + divider latency (2 if rejected).
// Backpressure: one request in flight; other requests wait at level until granted.
//   clk, rst_n            clock, async active-low reset
//   req/freq_in           per-channel level request and frequency word
//   discr_freq            common divisor (sample rate)
//   sample_en             commit strobe for staged increments
//   div                   divider bundle (master side)
//   ack                   one-cycle pulse per finished (or rejected) request
//   inc_arg/inc_rem       active per-channel increment, integer and fraction
//   busy/err_div0/err_sat status; error flags are sticky until reset
module cordic_freq_sched
  import cordic_pkg::*;
#(
  parameter int NCH = 4,
  parameter int FW  = 16,
  parameter int AW  = cordic_pkg::AW,
  parameter int DW  = cordic_pkg::DW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*FW-1:0] freq_in,
  input  logic [FW-1:0]     discr_freq,
  input  logic              sample_en,
  cordic_freq_sched_if.master div,
  output logic [NCH-1:0]    ack,
  output logic [NCH*AW-1:0] inc_arg,
  output logic [NCH*AW-1:0] inc_rem,
  output logic              busy,
  output logic              err_div0,
  output logic              err_sat
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [AW-1:0] SAT_ARG = {1'b0, {(AW-1){1'b1}}};

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, g_q, gnt_idx;
  logic [NCH-1:0]  gnt, g_oh_q, ack_q, pend_q;
  logic            any_req, rej_q, sat;
  logic [FW-1:0]   opnd_freq_q, opnd_discr_q;
  logic [DW-1:0]   quo_q;
  logic [AW-1:0]   rem_q;
  logic [AW-1:0]   stg_arg_q [NCH];
  logic [AW-1:0]   stg_rem_q [NCH];
  logic [AW-1:0]   act_arg_q [NCH];
  logic [AW-1:0]   act_rem_q [NCH];
  logic            unused_rem;

  // Only the low AW bits of the remainder are ever kept.
  assign unused_rem = ^div.div_remainder[DW-1:AW];

  rr_arbiter #(.NCH(NCH), .PW(PW)) u_arb (
    .req     (req),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any_req)
  );

  assign div.div_dividend = DW'(opnd_freq_q);
  assign div.div_divisor  = DW'(opnd_discr_q);
  assign ack              = ack_q;
  // Any set bit at or above the sign position of the phase word means overflow.
  assign sat              = |quo_q[DW-1:AW-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    busy          = (state_q != ST_IDLE);
    div.div_start = 1'b0;
    case (state_q)
      ST_IDLE:  if (any_req) state_d = (discr_freq == '0) ? ST_STORE : ST_START;
      ST_START: begin
        div.div_start = 1'b1;
        state_d       = ST_WAIT;
      end
      ST_WAIT:  if (div.div_ready) state_d = ST_STORE;
      ST_STORE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      g_q          <= '0;
      g_oh_q       <= '0;
      rej_q        <= 1'b0;
      opnd_freq_q  <= '0;
      opnd_discr_q <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      ack_q        <= '0;
      pend_q       <= '0;
      err_div0     <= 1'b0;
      err_sat      <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        stg_arg_q[i] <= '0;
        stg_rem_q[i] <= '0;
        act_arg_q[i] <= '0;
        act_rem_q[i] <= '0;
      end
    end else begin
      ack_q <= '0;

      // Commit reads staged values from before this edge, so a result stored
      // on the same edge stays pending for the next strobe.
      if (sample_en) begin
        for (int i = 0; i < NCH; i++) begin
          if (pend_q[i]) begin
            act_arg_q[i] <= stg_arg_q[i];
            act_rem_q[i] <= stg_rem_q[i];
            pend_q[i]    <= 1'b0;
          end
        end
      end

      case (state_q)
        ST_IDLE: if (any_req) begin
          g_q          <= gnt_idx;
          g_oh_q       <= gnt;
          opnd_freq_q  <= freq_in[int'(gnt_idx)*FW +: FW];
          opnd_discr_q <= discr_freq;
          rej_q        <= (discr_freq == '0);
        end
        ST_WAIT: if (div.div_ready) begin
          quo_q <= div.div_quotient;
          rem_q <= div.div_remainder[AW-1:0];
        end
        ST_STORE: begin
          ack_q    <= g_oh_q;
          rr_ptr_q <= (int'(g_q) == NCH - 1) ? '0 : g_q + 1'b1;
          if (rej_q) begin
            err_div0 <= 1'b1;
          end else begin
            stg_arg_q[g_q] <= sat ? SAT_ARG : quo_q[AW-1:0];
            stg_rem_q[g_q] <= sat ? '0 : rem_q;
            pend_q[g_q]    <= 1'b1;
            if (sat) err_sat <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    inc_arg = '0;
    inc_rem = '0;
    for (int i = 0; i < NCH; i++) begin
      inc_arg[i*AW +: AW] = act_arg_q[i];
      inc_rem[i*AW +: AW] = act_rem_q[i];
    end
  end

endmodule
